// File: rtl/packet_pkg.sv
// Shared types for the switch ingress path: FSM states, flit layout and
// header decode helper.
package packet_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DROP = 2'd3
    } port_fsm_e;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } flit_t;

    // Destination mask lives in the low bits of the header flit.
    function automatic logic [ADDR_WIDTH-1:0] hdr_dst(flit_t f);
        return f.data[ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output. A pop frees its slot
// in the same cycle, so push is accepted at full when a pop happens too.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage: contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally at power-of-two DEPTH; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/input_port_buffer.sv
// Store-and-forward ingress buffer for one switch input port. Requests the
// output arbiter once a whole packet is queued, streams it on grant, and
// silently drops packets whose header mask is zero.
module input_port_buffer import packet_pkg::*; #(
    parameter int DATA_WIDTH = packet_pkg::DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = packet_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  port_req,
    output logic [ADDR_WIDTH-1:0] port_dst,
    input  logic                  grant,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [7:0]            drop_cnt,
    output logic                  err_overflow
);

    logic [DATA_WIDTH:0]      head;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic                     push_last;
    logic                     pop_last;
    logic [$clog2(DEPTH):0]   pkt_cnt;
    port_fsm_e                state;
    flit_t                    head_flit;
    logic [ADDR_WIDTH-1:0]    head_dst;

    // Once overflow is flagged the port stays closed until reset.
    assign in_ready  = !rst && !full && !err_overflow;
    assign push      = in_valid && in_ready;
    assign pop       = ((state == XFER) || (state == DROP)) && !empty;
    assign head_flit = head;
    assign head_dst  = hdr_dst(head_flit);
    assign push_last = push && in_last;
    assign pop_last  = pop && head_flit.last;

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_last, in_data}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Count of complete packets held in the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (push_last && !pop_last) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end else if (pop_last && !push_last) begin
            pkt_cnt <= pkt_cnt - 1'b1;
        end
    end

    // A full FIFO with no packet boundary can never drain: flag it, sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overflow <= 1'b0;
        end else if (full && (pkt_cnt == '0)) begin
            err_overflow <= 1'b1;
        end
    end

    // Egress FSM: request, transfer or drop the packet at the FIFO head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            port_req  <= 1'b0;
            port_dst  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            drop_cnt  <= '0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pkt_cnt != '0) begin
                        if (head_dst != '0) begin
                            state    <= REQ;
                            port_req <= 1'b1;
                            port_dst <= head_dst;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                REQ: begin
                    if (grant) state <= XFER;
                end
                XFER: begin
                    if (pop) begin
                        out_valid <= 1'b1;
                        out_data  <= head_flit.data;
                        out_last  <= head_flit.last;
                        // Request is held through the packet so crossbar selects stay put.
                        if (head_flit.last) begin
                            state    <= IDLE;
                            port_req <= 1'b0;
                            port_dst <= '0;
                        end
                    end
                end
                DROP: begin
                    if (pop_last) begin
                        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer: cycle table for request/transfer/drop,
// plus hand sequences for overflow, streaming, mid-packet reset, saturation.
module tb_input_port_buffer;
    import packet_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        port_req;
    logic [3:0]  port_dst;
    logic        grant = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [7:0]  drop_cnt;
    logic        err_overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    input_port_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .port_req     (port_req),
        .port_dst     (port_dst),
        .grant        (grant),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .drop_cnt     (drop_cnt),
        .err_overflow (err_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        last;
        logic        gnt;
        logic        req;
        logic [3:0]  dst;
        logic        ov;
        logic        ol;
        logic [31:0] od;
        logic [7:0]  dc;
    } vec_t;

    function automatic vec_t mk(logic vld, logic [31:0] d, logic l, logic g, logic req,
                                logic [3:0] dst, logic ov, logic ol, logic [31:0] od, logic [7:0] dc);
        vec_t v;
        v.vld = vld; v.data = d; v.last = l; v.gnt = g; v.req = req;
        v.dst = dst; v.ov = ov; v.ol = ol; v.od = od; v.dc = dc;
        return v;
    endfunction

    localparam int NV = 22;
    localparam logic [31:0] D0 = 32'hA000_0002, D1 = 32'hA000_0011, D2 = 32'hA000_0022;
    localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB000_0001, C0 = 32'hC000_0009;
    vec_t vt [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one flit, waiting (bounded) for in_ready; returns whether it was taken.
    task automatic push_flit(input logic [31:0] d, input logic l, output logic ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int c = 0; c < 50 && !ok; c++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic ok;
        int   seen;
        int   got;
        logic all_ok;

        // Post-edge values, one row per clock; od only checked while ov.
        vt[0]  = mk(1, D0, 0, 0, 0, 4'h0, 0, 0, 0,  0);
        vt[1]  = mk(1, D1, 0, 0, 0, 4'h0, 0, 0, 0,  0);
        vt[2]  = mk(1, D2, 1, 0, 0, 4'h0, 0, 0, 0,  0);
        vt[3]  = mk(0, 0,  0, 0, 1, 4'h2, 0, 0, 0,  0);
        vt[4]  = mk(0, 0,  0, 0, 1, 4'h2, 0, 0, 0,  0);
        vt[5]  = mk(0, 0,  0, 0, 1, 4'h2, 0, 0, 0,  0);
        vt[6]  = mk(0, 0,  0, 0, 1, 4'h2, 0, 0, 0,  0);
        vt[7]  = mk(0, 0,  0, 0, 1, 4'h2, 0, 0, 0,  0);
        vt[8]  = mk(0, 0,  0, 1, 1, 4'h2, 0, 0, 0,  0);
        vt[9]  = mk(0, 0,  0, 0, 1, 4'h2, 1, 0, D0, 0);
        vt[10] = mk(0, 0,  0, 0, 1, 4'h2, 1, 0, D1, 0);
        vt[11] = mk(0, 0,  0, 0, 0, 4'h0, 1, 1, D2, 0);
        vt[12] = mk(0, 0,  0, 1, 0, 4'h0, 0, 0, 0,  0);
        vt[13] = mk(1, B0, 0, 0, 0, 4'h0, 0, 0, 0,  0);
        vt[14] = mk(1, B1, 1, 0, 0, 4'h0, 0, 0, 0,  0);
        vt[15] = mk(1, C0, 1, 0, 0, 4'h0, 0, 0, 0,  0);
        vt[16] = mk(0, 0,  0, 0, 0, 4'h0, 0, 0, 0,  0);
        vt[17] = mk(0, 0,  0, 0, 0, 4'h0, 0, 0, 0,  1);
        vt[18] = mk(0, 0,  0, 0, 1, 4'h9, 0, 0, 0,  1);
        vt[19] = mk(0, 0,  0, 1, 1, 4'h9, 0, 0, 0,  1);
        vt[20] = mk(0, 0,  0, 0, 0, 4'h0, 1, 1, C0, 1);
        vt[21] = mk(0, 0,  0, 0, 0, 4'h0, 0, 0, 0,  1);

        // Reset state
        #1 rst = 1'b1;
        #20;
        check("rst_in_ready", in_ready, 0);
        check("rst_port_req", port_req, 0);
        check("rst_port_dst", port_dst, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_err", err_overflow, 0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("rel_in_ready", in_ready, 1);

        // Table: request/hold/transfer, idle grant ignored, drop then single flit
        for (int i = 0; i < NV; i++) begin
            in_valid = vt[i].vld;
            in_data  = vt[i].data;
            in_last  = vt[i].last;
            grant    = vt[i].gnt;
            tick();
            check($sformatf("v%0d_in_ready", i), in_ready, 1);
            check($sformatf("v%0d_port_req", i), port_req, vt[i].req);
            check($sformatf("v%0d_port_dst", i), port_dst, vt[i].dst);
            check($sformatf("v%0d_out_valid", i), out_valid, vt[i].ov);
            check($sformatf("v%0d_out_last", i), out_last, vt[i].ol);
            if (vt[i].ov) check($sformatf("v%0d_out_data", i), out_data, vt[i].od);
            check($sformatf("v%0d_drop_cnt", i), drop_cnt, vt[i].dc);
        end
        in_valid = 1'b0;
        grant    = 1'b0;

        // Overflow: 16 flits with no last
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h7000_0000 + i;
            in_last  = 1'b0;
            check($sformatf("ovf_rdy%0d", i), in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        check("ovf_full_rdy", in_ready, 0);
        tick();
        check("ovf_err", err_overflow, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        check("ovf_err_held", err_overflow, 1);
        check("ovf_rdy_held", in_ready, 0);
        check("ovf_no_req", port_req, 0);
        #2 rst = 1'b1;
        #1;
        check("ovf_rst_err", err_overflow, 0);
        check("ovf_rst_rdy", in_ready, 0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("ovf_rel_rdy", in_ready, 1);

        // Streaming 2-flit packets with grant held high
        grant = 1'b1;
        got = 0;
        fork
            begin
                for (int p = 0; p < 6; p++)
                    for (int f = 0; f < 2; f++) begin
                        push_flit(32'h5000_0004 | (p << 8) | (f << 4), f == 1, ok);
                        check("stream_push", ok, 1);
                    end
            end
            begin
                for (int c = 0; c < 400 && got < 12; c++) begin
                    tick();
                    if (out_valid) begin
                        check($sformatf("stream_data%0d", got), out_data,
                              32'h5000_0004 | ((got / 2) << 8) | ((got % 2) << 4));
                        check($sformatf("stream_last%0d", got), out_last, (got % 2) == 1);
                        got++;
                    end
                end
            end
        join
        grant = 1'b0;
        check("stream_count", got, 12);
        tick();
        tick();
        check("stream_err", err_overflow, 0);
        check("stream_idle_req", port_req, 0);

        // Reset during transfer of a 4-flit packet
        for (int f = 0; f < 4; f++) push_flit(32'hE000_0001 + (f << 4), f == 3, ok);
        for (int c = 0; c < 20 && !port_req; c++) tick();
        check("rstx_req", port_req, 1);
        check("rstx_dst", port_dst, 4'h1);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen < 2; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check("rstx_seen", seen, 2);
        check("rstx_flit2", out_data, 32'hE000_0011);
        #2 rst = 1'b1;
        #1;
        check("rstx_req0", port_req, 0);
        check("rstx_dst0", port_dst, 0);
        check("rstx_ov0", out_valid, 0);
        check("rstx_ol0", out_last, 0);
        check("rstx_od0", out_data, 0);
        check("rstx_rdy0", in_ready, 0);
        @(negedge clk) rst = 1'b0;
        all_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (port_req || out_valid) all_ok = 1'b0;
        end
        check("rstx_no_stale", all_ok, 1);
        push_flit(32'hF000_0002, 1'b1, ok);
        for (int c = 0; c < 10 && !port_req; c++) tick();
        check("rstx_new_req", port_req, 1);
        check("rstx_new_dst", port_dst, 4'h2);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        tick();
        check("rstx_new_data", out_data, 32'hF000_0002);
        check("rstx_new_last", out_last, 1);

        // Drop counter saturation: 257 zero-mask single-flit packets
        all_ok = 1'b1;
        for (int i = 0; i < 257; i++) begin
            push_flit(i << 8, 1'b1, ok);
            if (!ok || out_valid || port_req) all_ok = 1'b0;
        end
        check("sat_push_ok", all_ok, 1);
        for (int c = 0; c < 60; c++) tick();
        check("sat_drop_cnt", drop_cnt, 8'hFF);
        check("sat_no_req", port_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
